// File: rtl/atm_machine.sv
`default_nettype none
// ============================================================================
// Module      : atm_machine
// Description : Moore control FSM for a simplified ATM session: card insert,
//               PIN entry with one retry, amount check against an internal
//               balance, one-cycle dispense, card return, alarm lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module atm_machine #(
    parameter logic [15:0] CORRECT_PIN  = 16'd1234,
    parameter logic [15:0] INIT_BALANCE = 16'd5000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        x_in,
    input  logic [15:0] inputPin1,
    input  logic [15:0] inputPin2,
    input  logic [15:0] amount,
    output logic        green,
    output logic        red,
    output logic        alarm,
    output logic        cardInserted,
    output logic        cardValid,
    output logic        dispensingAmount,
    output logic        takeInCard,
    output logic [2:0]  state,
    output logic [2:0]  next_state
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CARD_IN  = 3'd1;
    localparam logic [2:0] c_PIN1     = 3'd2;
    localparam logic [2:0] c_PIN2     = 3'd3;
    localparam logic [2:0] c_AMOUNT   = 3'd4;
    localparam logic [2:0] c_DISPENSE = 3'd5;
    localparam logic [2:0] c_EJECT    = 3'd6;
    localparam logic [2:0] c_LOCK     = 3'd7;

    logic [2:0]  r_state;
    logic [15:0] r_balance;
    logic        r_green;
    logic        r_red;
    logic        r_alarm;
    logic        r_card_inserted;
    logic        r_card_valid;
    logic        r_dispensing;
    logic        r_take_in_card;

    logic [2:0]  w_next_state;
    logic        w_amount_ok;
    logic        w_debit;
    logic [6:0]  w_next_outs;

    // A withdrawal is honoured only when non-zero and covered by the balance,
    // which also guarantees the balance can never wrap below zero.
    assign w_amount_ok = (amount != 16'd0) && (amount <= r_balance);
    assign w_debit     = (r_state == c_AMOUNT) && x_in && w_amount_ok;

    // Next-state logic: every state holds without x_in except DISPENSE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:     if (x_in) w_next_state = c_CARD_IN;
            c_CARD_IN:  if (x_in) w_next_state = c_PIN1;
            c_PIN1:     if (x_in) w_next_state = (inputPin1 == CORRECT_PIN) ? c_AMOUNT : c_PIN2;
            c_PIN2:     if (x_in) w_next_state = (inputPin2 == CORRECT_PIN) ? c_AMOUNT : c_LOCK;
            c_AMOUNT:   if (x_in) w_next_state = w_amount_ok ? c_DISPENSE : c_EJECT;
            c_DISPENSE: w_next_state = c_EJECT;
            c_EJECT:    if (x_in) w_next_state = c_IDLE;
            default:    w_next_state = c_LOCK;
        endcase
    end

    // Indicator pattern of the state being entered, so the registered
    // outputs always line up with the registered state.
    // Order: green, red, alarm, cardInserted, cardValid, dispensing, takeInCard.
    always_comb begin
        w_next_outs = 7'b0000000;
        case (w_next_state)
            c_IDLE:     w_next_outs = 7'b0000000;
            c_CARD_IN:  w_next_outs = 7'b0001000;
            c_PIN1:     w_next_outs = 7'b0001000;
            c_PIN2:     w_next_outs = 7'b0101000;
            c_AMOUNT:   w_next_outs = 7'b1001100;
            c_DISPENSE: w_next_outs = 7'b1001110;
            c_EJECT:    w_next_outs = 7'b0001001;
            default:    w_next_outs = 7'b0111000;
        endcase
    end

    // State, balance and indicator registers; reset restores a fresh account.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= c_IDLE;
            r_balance       <= INIT_BALANCE;
            r_green         <= 1'b0;
            r_red           <= 1'b0;
            r_alarm         <= 1'b0;
            r_card_inserted <= 1'b0;
            r_card_valid    <= 1'b0;
            r_dispensing    <= 1'b0;
            r_take_in_card  <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            if (w_debit) begin
                r_balance <= r_balance - amount;
            end
            r_green         <= w_next_outs[6];
            r_red           <= w_next_outs[5];
            r_alarm         <= w_next_outs[4];
            r_card_inserted <= w_next_outs[3];
            r_card_valid    <= w_next_outs[2];
            r_dispensing    <= w_next_outs[1];
            r_take_in_card  <= w_next_outs[0];
        end
    end

    assign state            = r_state;
    assign next_state       = w_next_state;
    assign green            = r_green;
    assign red              = r_red;
    assign alarm            = r_alarm;
    assign cardInserted     = r_card_inserted;
    assign cardValid        = r_card_valid;
    assign dispensingAmount = r_dispensing;
    assign takeInCard       = r_take_in_card;

endmodule
`default_nettype wire

// File: tb/tb_atm_machine.sv
`default_nettype none
// ============================================================================
// Module      : tb_atm_machine
// Description : Self-checking bench for atm_machine: directed sessions with
//               literal expectations plus randomized sessions compared against
//               a behavioural model of the ATM flow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atm_machine;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        x_in = 1'b0;
    logic [15:0] inputPin1 = 16'd0;
    logic [15:0] inputPin2 = 16'd0;
    logic [15:0] amount = 16'd0;
    logic        green, red, alarm, cardInserted, cardValid, dispensingAmount, takeInCard;
    logic [2:0]  state, next_state;

    int errors = 0;
    int checks = 0;

    // Behavioural model: session step number and account balance.
    int m_state = 0;
    int m_bal   = 5000;

    atm_machine dut (
        .clock(clock), .reset(reset), .x_in(x_in),
        .inputPin1(inputPin1), .inputPin2(inputPin2), .amount(amount),
        .green(green), .red(red), .alarm(alarm), .cardInserted(cardInserted),
        .cardValid(cardValid), .dispensingAmount(dispensingAmount),
        .takeInCard(takeInCard), .state(state), .next_state(next_state)
    );

    always #5 clock = ~clock;

    // Where the session goes next, from the flow rules.
    function automatic int model_next(int s, logic x, int p1, int p2, int amt, int bal);
        case (s)
            0: return x ? 1 : 0;
            1: return x ? 2 : 1;
            2: return x ? ((p1 == 1234) ? 4 : 3) : 2;
            3: return x ? ((p2 == 1234) ? 4 : 7) : 3;
            4: return x ? ((amt != 0 && amt <= bal) ? 5 : 6) : 4;
            5: return 6;
            6: return x ? 0 : 6;
            default: return 7;
        endcase
    endfunction

    // Indicator pattern per step: green, red, alarm, cardIn, cardValid, dispense, takeCard.
    function automatic logic [6:0] model_outs(int s);
        logic [6:0] tbl [8];
        tbl = '{7'b0000000, 7'b0001000, 7'b0001000, 7'b0101000,
                7'b1001100, 7'b1001110, 7'b0001001, 7'b0111000};
        return tbl[s];
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_state <= 0;
            m_bal   <= 5000;
        end else begin
            if (x_in && m_state == 4 && amount != 0 && int'(amount) <= m_bal)
                m_bal <= m_bal - int'(amount);
            m_state <= model_next(m_state, x_in, int'(inputPin1), int'(inputPin2),
                                  int'(amount), m_bal);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_outs();
        return int'({green, red, alarm, cardInserted, cardValid, dispensingAmount, takeInCard});
    endfunction

    // Drive inputs just after a falling edge, then compare at the next falling edge.
    task automatic step(input logic x, input int p1, input int p2, input int amt);
        x_in      = x;
        inputPin1 = 16'(p1);
        inputPin2 = 16'(p2);
        amount    = 16'(amt);
        @(negedge clock);
        chk("state", int'(state), m_state);
        chk("outputs", dut_outs(), int'(model_outs(m_state)));
        chk("next_state", int'(next_state),
            model_next(m_state, x_in, int'(inputPin1), int'(inputPin2), int'(amount), m_bal));
    endtask

    task automatic expect_path(input string name, input int p1, input int p2,
                               input int amt, input int n, input int seq [8]);
        for (int i = 0; i < n; i++) begin
            step(1'b1, p1, p2, amt);
            chk(name, int'(state), seq[i]);
        end
    endtask

    int disp_cycles;

    initial begin
        // Reset held with x_in toggling: nothing moves.
        for (int i = 0; i < 10; i++) begin
            step(i[0], 1234, 0, 1500);
            chk("reset_held_state", int'(state), 0);
            chk("reset_held_outs", dut_outs(), 0);
        end
        reset = 1'b1;

        // Happy path.
        disp_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            int seq [6];
            seq = '{1, 2, 4, 5, 6, 0};
            step(1'b1, 1234, 0, 1500);
            chk("happy_seq", int'(state), seq[i]);
            if (dispensingAmount) disp_cycles++;
        end
        chk("dispense_cycles", disp_cycles, 1);
        chk("model_balance_after_1500", m_bal, 3500);

        // 6000 exceeds the remaining 3500: straight to eject.
        expect_path("refuse_6000", 1234, 0, 6000, 5, '{1, 2, 4, 6, 0, 0, 0, 0});
        // Zero amount refused.
        expect_path("refuse_zero", 1234, 0, 0, 5, '{1, 2, 4, 6, 0, 0, 0, 0});

        // Retry success.
        expect_path("retry", 1111, 1234, 100, 3, '{1, 2, 3, 0, 0, 0, 0, 0});
        chk("retry_red", int'(red), 1);
        step(1'b1, 1111, 1234, 100);
        chk("retry_amount", int'(state), 4);
        chk("retry_green_valid", int'({green, cardValid}), 3);
        expect_path("retry_tail", 1111, 1234, 100, 3, '{5, 6, 0, 0, 0, 0, 0, 0});

        // Lockout is absorbing.
        expect_path("lock", 1111, 2222, 100, 4, '{1, 2, 3, 7, 0, 0, 0, 0});
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1234, 1234, 100);
            chk("lock_alarm", int'({alarm, red}), 3);
        end
        #2 reset = 1'b0;
        #1 chk("lock_cleared", int'({alarm, red, state}), 0);
        step(1'b0, 0, 0, 0);
        reset = 1'b1;

        // Async reset while dispensing restores the full balance.
        expect_path("to_dispense", 1234, 0, 1500, 4, '{1, 2, 4, 5, 0, 0, 0, 0});
        #2 reset = 1'b0;
        #1 chk("async_state", int'(state), 0);
        chk("async_outs", dut_outs(), 0);
        step(1'b0, 0, 0, 0);
        reset = 1'b1;

        // Whole balance may be withdrawn; afterwards even 1 is refused.
        expect_path("drain_5000", 1234, 0, 5000, 6, '{1, 2, 4, 5, 6, 0, 0, 0});
        chk("model_balance_zero", m_bal, 0);
        expect_path("refuse_1", 1234, 0, 1, 5, '{1, 2, 4, 6, 0, 0, 0, 0});

        // Randomized sessions against the model, with occasional async resets.
        for (int i = 0; i < 600; i++) begin
            int amt, p1, p2;
            case ($urandom_range(0, 3))
                0: amt = 0;
                1: amt = m_bal;
                2: amt = int'($urandom_range(1, 7000));
                default: amt = m_bal + 1;
            endcase
            p1 = ($urandom_range(0, 1) == 1) ? 1234 : int'($urandom_range(0, 65535));
            p2 = ($urandom_range(0, 1) == 1) ? 1234 : int'($urandom_range(0, 65535));
            reset = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, p1, p2, amt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/atm_machine.md
Name: atm_machine

Overview:
- Moore-style control FSM for a simplified ATM: card insertion, PIN entry with one retry, amount check against an internal balance, cash dispense, card return.
- Locks into an alarm state after two wrong PINs.
- A single user strobe `x_in` advances the flow; PINs and amount arrive as 16-bit words.
- Exposes current and next state for debug and verification.

Parameters:
- CORRECT_PIN, 16'd1234, stored PIN compared against both PIN inputs.
- INIT_BALANCE, 16'd5000, account balance loaded on reset.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous active-low reset.
- x_in  input  1  user advance/confirm strobe, sampled on rising clock edge.
- inputPin1  input  16  first PIN attempt, unsigned.
- inputPin2  input  16  second (retry) PIN attempt, unsigned.
- amount  input  16  requested withdrawal, unsigned.
- green  output  1  PIN accepted indicator.
- red  output  1  error indicator.
- alarm  output  1  lockout alarm.
- cardInserted  output  1  card present and session active.
- cardValid  output  1  PIN verified.
- dispensingAmount  output  1  cash being dispensed.
- takeInCard  output  1  prompt user to take card.
- state  output  3  current state register.
- next_state  output  3  combinational next state.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-low on `reset`.
- While `reset`=0:
  - state = IDLE, regardless of clock or `x_in`.
  - balance = INIT_BALANCE.
  - All indicator outputs 0.
- On release of reset, operation resumes at the next rising edge.
- All outputs except `next_state` are registered state or decoded from state only (Moore). `next_state` is combinational from state, `x_in`, `inputPin1`, `inputPin2`, `amount` and balance.
- Every transition takes exactly one clock. With `x_in`=0, every state except DISPENSE holds.
- State encodings and transitions:
  - IDLE 000: all outputs 0. x_in=1 → CARD_IN.
  - CARD_IN 001: cardInserted=1. x_in=1 → PIN1.
  - PIN1 010: cardInserted=1. x_in=1: inputPin1==CORRECT_PIN → AMOUNT, else → PIN2.
  - PIN2 011: cardInserted=1, red=1. x_in=1: inputPin2==CORRECT_PIN → AMOUNT, else → LOCK.
  - AMOUNT 100: cardInserted=1, cardValid=1, green=1. x_in=1:
    - 0 < amount ≤ balance → DISPENSE, and balance ← balance − amount on that same edge.
    - otherwise → EJECT, balance unchanged.
  - DISPENSE 101: cardInserted=1, cardValid=1, green=1, dispensingAmount=1. Lasts exactly one cycle, then → EJECT unconditionally; `x_in` ignored.
  - EJECT 110: takeInCard=1, cardInserted=1. x_in=1 → IDLE.
  - LOCK 111: alarm=1, red=1, cardInserted=1 (card retained). Absorbing; only reset exits.
- Balance:
  - 16-bit unsigned, internal, persists across sessions.
  - Cannot underflow, because amount > balance is refused.
  - amount == balance is allowed and leaves balance 0.
  - amount == 0 is refused.
- PIN compare: full 16-bit equality. No BCD interpretation.
- Input timing: inputs are sampled only in their own state on the edge where x_in=1. Changes at other times have no effect.
- Reset mid-session: any state, including DISPENSE and LOCK, returns to IDLE asynchronously. Balance also restores to INIT_BALANCE.
- Back-to-back `x_in`: x_in held 1 advances one state per clock.

Test Plan:
- Reset held: `reset`=0 for 100 ns, x_in toggling, inputPin1=1234, amount=1500 → state stays 000, every indicator 0.
- Happy path: `reset`=1, x_in=1 continuously, inputPin1=1234, amount=1500 → state sequence 000→001→010→100→101→110→000. dispensingAmount high for exactly one cycle. Balance becomes 3500.
- Retry success: inputPin1=1111, inputPin2=1234 → PIN1→PIN2, red=1, then AMOUNT with green=1 and cardValid=1.
- Lockout: inputPin1=1111, inputPin2=2222 → LOCK (111), alarm=1 and red=1. Alarm stays high after 10 more cycles of x_in=1 and clears only when reset is asserted.
- Insufficient funds and zero amount:
  - amount=6000 → AMOUNT→EJECT, no dispense, balance stays 5000.
  - amount=0 → same result.
  - amount=5000 → dispense, balance 0. A second session with amount=1 → EJECT.
- Async reset mid-operation: assert reset between clock edges while in DISPENSE → state=000 immediately, without waiting for an edge. Outputs cleared, balance back to 5000.
